// File: rtl/ex_div_seq_pkg.sv
// Shared types for the sequential EX-stage divider: FSM state encoding and
// the divide-by-zero quotient fill bit.
package ex_div_seq_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivCalc = 2'd1,
        DivFix  = 2'd2,
        DivDone = 2'd3
    } div_state_e;

    // Replicated to WIDTH bits to form the all-ones divide-by-zero quotient.
    localparam logic DivDbzFill = 1'b1;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One radix-2 restoring iteration, purely combinational; shift in one dividend
// bit, trial-subtract the divisor magnitude, keep the difference if no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] diff;

    always_comb begin
        diff  = {rem_i, bit_i} - {2'b00, dvs_i};
        // Top bit of the difference is the borrow of the trial subtraction.
        q_o   = ~diff[WIDTH+1];
        rem_o = q_o ? diff[WIDTH:0] : {rem_i[WIDTH-1:0], bit_i};
    end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU): WIDTH+2 cycles start-to-valid, one
// cycle for divide-by-zero; busy_o stalls EX, cancel_i flushes, results hold until next valid_o.
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             dbz_o
);

    localparam logic [WIDTH-1:0] DivDbzQuotient = {WIDTH{DivDbzFill}};
    localparam logic [CNT_W-1:0] CntLast        = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic             signed_q;
    logic             neg_dvd_q;
    logic             neg_dvs_q;
    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             valid_q;
    logic             busy_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_d;
    logic             qbit_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivIdle;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            signed_q  <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (cancel_i) begin
            state_q <= DivIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                DivIdle, DivDone: begin
                    state_q <= DivIdle;
                    valid_q <= 1'b0;
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            state_q   <= DivDone;
                            quo_out_q <= DivDbzQuotient;
                            rem_out_q <= dividend_i;
                            dbz_q     <= 1'b1;
                            valid_q   <= 1'b1;
                        end else begin
                            state_q   <= DivCalc;
                            dvd_q     <= magnitude(dividend_i, signed_i);
                            dvs_q     <= magnitude(divisor_i, signed_i);
                            signed_q  <= signed_i;
                            neg_dvd_q <= signed_i & dividend_i[WIDTH-1];
                            neg_dvs_q <= signed_i & divisor_i[WIDTH-1];
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                DivCalc: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= DivFix;
                    end
                end
                DivFix: begin
                    // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) negates to MIN.
                    quo_out_q <= (signed_q && (neg_dvd_q != neg_dvs_q)) ? -dvd_q : dvd_q;
                    rem_out_q <= (signed_q && neg_dvd_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_q     <= 1'b0;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= DivDone;
                end
                default: begin
                    state_q <= DivIdle;
                end
            endcase
        end
    end

    assign quotient_o  = quo_out_q;
    assign remainder_o = rem_out_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Bench for ex_div_seq at WIDTH=32 and WIDTH=8, checked against an arithmetic
// reference model and fixed directed vectors.
module tb_ex_div_seq;

    logic        clk;
    logic        rst;
    logic        a_start, a_signed, a_cancel, a_valid, a_busy, a_dbz;
    logic [31:0] a_dvd, a_dvs, a_q, a_r;
    logic        b_start, b_signed, b_cancel, b_valid, b_busy, b_dbz;
    logic [7:0]  b_dvd, b_dvs, b_q, b_r;

    int n_checks = 0;
    int n_fail   = 0;

    ex_div_seq #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst(rst), .start_i(a_start), .signed_i(a_signed), .cancel_i(a_cancel),
        .dividend_i(a_dvd), .divisor_i(a_dvs), .quotient_o(a_q), .remainder_o(a_r),
        .valid_o(a_valid), .busy_o(a_busy), .dbz_o(a_dbz)
    );

    ex_div_seq #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start_i(b_start), .signed_i(b_signed), .cancel_i(b_cancel),
        .dividend_i(b_dvd), .divisor_i(b_dvs), .quotient_o(b_q), .remainder_o(b_r),
        .valid_o(b_valid), .busy_o(b_busy), .dbz_o(b_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; signed results truncate toward zero.
    function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input bit sgn, output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            q = mask;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
            sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
            q  = sa / sb;
            r  = sa % sb;
            q  = q & mask;
            r  = r & mask;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to its valid_o pulse (bounded wait).
    task automatic run_op(input bit w8, input logic [63:0] a, input logic [63:0] b, input bit sgn,
                          output logic [63:0] q, output logic [63:0] r, output bit dbz,
                          output int lat, output bit busy_bad);
        bit v, bsy;
        busy_bad = 1'b0;
        lat      = -1;
        if (w8) begin
            b_dvd = a[7:0]; b_dvs = b[7:0]; b_signed = sgn; b_start = 1'b1;
        end else begin
            a_dvd = a[31:0]; a_dvs = b[31:0]; a_signed = sgn; a_start = 1'b1;
        end
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            v   = w8 ? b_valid : a_valid;
            bsy = w8 ? b_busy  : a_busy;
            if (v) begin
                lat = k;
                if (bsy) busy_bad = 1'b1;
                break;
            end
            if (!bsy) busy_bad = 1'b1;
            tick();
        end
        q   = w8 ? {56'd0, b_q} : {32'd0, a_q};
        r   = w8 ? {56'd0, b_r} : {32'd0, a_r};
        dbz = w8 ? b_dbz : a_dbz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a_valid, a_busy, a_dbz} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags32: got %b, expected 000", {a_valid, a_busy, a_dbz});
        end
        n_checks++;
        if ({a_q, a_r} !== 64'd0) begin
            n_fail++; $display("FAIL reset_data32: got %h, expected 0", {a_q, a_r});
        end
        n_checks++;
        if ({b_valid, b_busy, b_dbz, b_q, b_r} !== 19'd0) begin
            n_fail++; $display("FAIL reset_all8: got %h, expected 0", {b_valid, b_busy, b_dbz, b_q, b_r});
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        bit          s;
        logic [31:0] q, r;
        bit          dbz;
    } vec_t;

    task automatic test_directed32();
        vec_t vecs[6];
        logic [63:0] q, r;
        bit dbz, bb;
        int lat;
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        vecs[5] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, {32'd0, vecs[i].a}, {32'd0, vecs[i].b}, vecs[i].s, q, r, dbz, lat, bb);
            n_checks++;
            if (q[31:0] !== vecs[i].q || r[31:0] !== vecs[i].r || dbz !== vecs[i].dbz) begin
                n_fail++;
                $display("FAIL directed%0d_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                         i, q[31:0], r[31:0], dbz, vecs[i].q, vecs[i].r, vecs[i].dbz);
            end
            n_checks++;
            if (lat !== (vecs[i].dbz ? 0 : 33)) begin
                n_fail++; $display("FAIL directed%0d_latency: got %0d, expected %0d", i, lat, vecs[i].dbz ? 0 : 33);
            end
            n_checks++;
            if (bb) begin
                n_fail++; $display("FAIL directed%0d_busy: got irregular busy_o, expected high only while computing", i);
            end
            tick();
            n_checks++;
            if (a_valid !== 1'b0 || a_q !== vecs[i].q || a_r !== vecs[i].r || a_dbz !== vecs[i].dbz) begin
                n_fail++;
                $display("FAIL directed%0d_hold: got valid=%b q=%h r=%h dbz=%b, expected valid=0 q=%h r=%h dbz=%b",
                         i, a_valid, a_q, a_r, a_dbz, vecs[i].q, vecs[i].r, vecs[i].dbz);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, mask, eq, er, q, r;
        bit w8, sgn, dbz, bb;
        int w, lat;
        for (int i = 0; i < 40; i++) begin
            w8   = 1'($urandom_range(0, 1));
            w    = w8 ? 8 : 32;
            mask = (64'd1 << w) - 64'd1;
            sgn  = 1'($urandom_range(0, 1));
            a    = {32'd0, $urandom} & mask;
            case ($urandom_range(0, 5))
                0:       b = 64'd0;
                1:       b = mask;
                2:       b = 64'($urandom_range(1, 15));
                default: b = {32'd0, $urandom} & mask;
            endcase
            if ($urandom_range(0, 7) == 0) a = 64'd1 << (w - 1);
            ref_div(w, a, b, sgn, eq, er);
            run_op(w8, a, b, sgn, q, r, dbz, lat, bb);
            n_checks++;
            if (q !== eq || r !== er || dbz !== (b == 64'd0)) begin
                n_fail++;
                $display("FAIL random%0d_w%0d_s%0d: %h/%h got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                         i, w, sgn, a, b, q, r, dbz, eq, er, (b == 64'd0));
            end
            n_checks++;
            if (lat !== ((b == 64'd0) ? 0 : w + 1) || bb) begin
                n_fail++;
                $display("FAIL random%0d_timing: got latency=%0d busy_bad=%b, expected latency=%0d busy_bad=0",
                         i, lat, bb, (b == 64'd0) ? 0 : w + 1);
            end
        end
        tick();
    endtask

    task automatic test_cancel();
        logic [31:0] pq, pr;
        logic [63:0] q, r;
        bit dbz, bb, saw;
        int lat;
        pq  = a_q;
        pr  = a_r;
        saw = 1'b0;
        a_dvd = 32'hFFFF_0000; a_dvs = 32'd5; a_signed = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (a_valid) saw = 1'b1;
        end
        a_cancel = 1'b1;
        tick();
        a_cancel = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_q !== pq || a_r !== pr) begin
            n_fail++;
            $display("FAIL cancel_state: got busy=%b valid=%b q=%h r=%h, expected busy=0 valid=0 q=%h r=%h",
                     a_busy, a_valid, a_q, a_r, pq, pr);
        end
        tick();
        if (a_valid) saw = 1'b1;
        run_op(1'b0, 64'd9, 64'd3, 1'b0, q, r, dbz, lat, bb);
        n_checks++;
        if (saw) begin
            n_fail++; $display("FAIL cancel_no_valid: got valid_o for aborted op, expected none");
        end
        n_checks++;
        if (q[31:0] !== 32'd3 || r[31:0] !== 32'd0 || lat !== 33 || bb) begin
            n_fail++;
            $display("FAIL cancel_restart: got q=%h r=%h lat=%0d busy_bad=%b, expected q=3 r=0 lat=33 busy_bad=0",
                     q[31:0], r[31:0], lat, bb);
        end
        tick();
        a_dvd = 32'd50; a_dvs = 32'd5; a_start = 1'b1; a_cancel = 1'b1;
        tick();
        a_start = 1'b0; a_cancel = 1'b0;
        tick();
        n_checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
            n_fail++; $display("FAIL cancel_with_start: got busy=%b valid=%b, expected busy=0 valid=0", a_busy, a_valid);
        end
    endtask

    task automatic test_rst_mid();
        a_dvd = 32'd1000; a_dvs = 32'd7; a_signed = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a_valid, a_busy, a_dbz, a_q, a_r} !== 67'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b busy=%b dbz=%b q=%h r=%h, expected all 0",
                     a_valid, a_busy, a_dbz, a_q, a_r);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (a_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL rst_mid_late_valid: got valid=1, expected 0");
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q, r;
        bit dbz, bb;
        int lat;
        run_op(1'b1, 64'd200, 64'd3, 1'b0, q, r, dbz, lat, bb);
        n_checks++;
        if (q !== 64'd66 || r !== 64'd2 || dbz !== 1'b0 || lat !== 9 || bb) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h r=%h dbz=%b lat=%0d busy_bad=%b, expected q=42 r=02 dbz=0 lat=9 busy_bad=0",
                     q, r, dbz, lat, bb);
        end
        run_op(1'b1, 64'h80, 64'hFF, 1'b1, q, r, dbz, lat, bb);
        n_checks++;
        if (q !== 64'h80 || r !== 64'd0 || dbz !== 1'b0 || lat !== 9 || bb) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h r=%h dbz=%b lat=%0d busy_bad=%b, expected q=80 r=00 dbz=0 lat=9 busy_bad=0",
                     q, r, dbz, lat, bb);
        end
        tick();
        n_checks++;
        if (b_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_pulse: got valid=%b, expected 0", b_valid);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_start = 1'b0; a_signed = 1'b0; a_cancel = 1'b0; a_dvd = '0; a_dvs = '0;
        b_start = 1'b0; b_signed = 1'b0; b_cancel = 1'b0; b_dvd = '0; b_dvs = '0;
        #2;
        test_reset();
        test_directed32();
        test_random();
        test_cancel();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Parametrised multi-cycle radix-2 restoring integer divider for the EX stage.
- Successor to the fixed 32-bit divider. Adds:
  - generic WIDTH;
  - explicit start/busy/valid handshake;
  - pipeline-flush cancel;
  - divide-by-zero flag with a defined result;
  - back-to-back operation.
- EX holds the pipeline stall on busy_o. EX writes HI/LO from remainder_o/quotient_o when valid_o is high.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  request; sampled only in IDLE or DONE
- signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- cancel_i  input  1  flush; aborts any operation
- dividend_i  input  WIDTH  dividend, sampled with start_i
- divisor_i  input  WIDTH  divisor, sampled with start_i
- quotient_o  output  WIDTH  quotient (to LO)
- remainder_o  output  WIDTH  remainder (to HI)
- valid_o  output  1  one-cycle pulse, results valid
- busy_o  output  1  high in CALC and FIX; EX stalls on it
- dbz_o  output  1  divisor was zero; qualified by valid_o

Behaviour:

Reset and priority:
- rst high at an edge: state = IDLE; valid_o, busy_o, dbz_o = 0; quotient_o, remainder_o = 0; counter = 0.
- Priority at every edge: rst > cancel_i > start_i.

States (IDLE, CALC, FIX, DONE), 2-bit encoding:
- IDLE:
  - start_i & divisor_i != 0: latch magnitudes of both operands (two's-complement negate when signed_i and MSB = 1), latch signs and signed_i, clear partial remainder and counter, go to CALC.
  - start_i & divisor_i == 0: go to DONE. quotient_o = all ones, remainder_o = dividend_i, dbz_o = 1, valid_o = 1.
- CALC, one iteration per cycle:
  - Shift the next dividend bit into the WIDTH+1-bit partial remainder.
  - Trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and shift 1 into the quotient; else shift 0.
  - Counter increments. The edge where the counter = WIDTH-1 goes to FIX.
- FIX:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative; the remainder sign follows the dividend.
  - Register the corrected results to the outputs, valid_o = 1, dbz_o = 0, go to DONE.
- DONE:
  - valid_o is high for this single cycle.
  - start_i is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE with valid_o = 0.

Timing and output holding:
- Latency with start accepted at edge n and a nonzero divisor: CALC on edges n+1..n+WIDTH, valid_o high in the cycle after edge n+WIDTH+1.
- busy_o is high from edge n until edge n+WIDTH+1.
- Divide-by-zero: valid_o high in the cycle after edge n; busy_o stays low.
- quotient_o, remainder_o and dbz_o hold their last values until the next valid_o. They are not cleared when returning to IDLE.

start_i handling:
- start_i in CALC or FIX is ignored.
- The requester keeps start_i low while busy_o is high.

cancel_i:
- In any state: next state IDLE, valid_o = 0, busy_o = 0.
- Outputs keep their previous results.
- cancel_i together with start_i: the start is dropped.

Signed overflow:
- MIN / -1 needs no special case and gives quotient = MIN, remainder = 0.
- The MIN magnitude 2^(WIDTH-1) fits in the unsigned magnitude register.

Width rules:
- Magnitude registers are WIDTH bits, unsigned.
- Partial remainder is WIDTH+1 bits; the trial difference uses its top bit as the borrow.

rst mid-operation: behaves as reset; any pending result is lost.

Decomposition:
- Shared defines file (defines.v) gains:
  - state encodings DivIdle, DivCalc, DivFix, DivDone;
  - DivDbzQuotient (all ones) as a WIDTH-replicated constant.
- One natural sub-module, div_step:
  - purely combinational single iteration;
  - inputs: partial remainder, next dividend bit, divisor magnitude;
  - outputs: new partial remainder, quotient bit.
  - Instantiated once and reused in a future unrolled radix-4 variant.

Test Plan:
- WIDTH=32, unsigned, 100 / 7, start at edge n -> valid_o in cycle after edge n+33, quotient_o=14, remainder_o=2, dbz_o=0; busy_o high for edges n..n+32.
- WIDTH=32, signed, 0xFFFFFFF9 / 2 (i.e. -7/2) -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> quotient_o=0xFFFFFFFD, remainder_o=1.
- 0x80000000 / 0xFFFFFFFF: signed -> quotient_o=0x80000000, remainder_o=0; unsigned -> quotient_o=0, remainder_o=0x80000000.
- Divisor 0, dividend 0x12345678 -> valid_o one cycle after start edge, quotient_o=0xFFFFFFFF, remainder_o=0x12345678, dbz_o=1, busy_o never high.
- cancel_i pulsed at edge n+10 of a running divide, then a new start at n+12 with 9/3 -> no valid_o for the aborted operation; valid_o after edge n+45 with quotient 3, remainder 0. Repeat with rst at n+10 -> all outputs 0.
- WIDTH=8, unsigned 200/3, then immediate back-to-back start in DONE with signed 0x80/0xFF -> first valid at n+9 with 66 r 2; second valid 10 cycles later with 0x80 r 0.
